prio_encoder_rr: RTL and testbench

- Parametrised, registered successor to the team's 8-to-3 one-hot encoder.
- Takes an N-bit request vector through a valid/ready input handshake and returns the encoded index of one asserted bit through a valid/ready output handshake.
- Selection is fixed-priority (LSB first) or round-robin, set by parameter.
- Flags zero and multi-hot inputs instead of driving X, and keeps a saturating count of non-one-hot inputs.
- Sits between request sources (interrupt lines, channel requests) and downstream index consumers.

---
 rtl/prio_encoder_pkg.sv | 23 ++
 rtl/prio_pick.sv | 38 +++
 rtl/prio_encoder_rr.sv | 78 +++++++
 tb/tb_prio_encoder_rr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_pkg.sv
// Shared constants and input classification for the registered priority encoder.
package prio_encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } vec_class_e;

  // Request vectors are zero-extended to 64 bits; v & (v-1) clears the lowest set bit.
  function automatic vec_class_e classify(input logic [63:0] v);
    if (v == 64'd0)
      return CLS_ZERO;
    else if ((v & (v - 64'd1)) == 64'd0)
      return CLS_ONE;
    else
      return CLS_MULTI;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational masked priority search: lowest set bit at or above start, wrapping to the
// lowest set bit overall when nothing at or above start is set.
module prio_pick
  import prio_encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = MODE_FIXED
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0]   start_eff;
  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;
  logic [W:0]     pos;

  assign start_eff = (MODE == MODE_RR) ? start : '0;
  assign hi_mask   = {N{1'b1}} << start_eff;

  // Lower half holds only bits at/above start; upper half is the full vector,
  // so the lowest set bit of dbl is the wrapped round-robin winner.
  assign dbl = {req, req & hi_mask};

  always_comb begin
    pos = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) pos = (W+1)'(i);
    end
  end

  assign idx   = (pos >= (W+1)'(N)) ? W'(pos - (W+1)'(N)) : W'(pos);
  assign found = |req;

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-bit priority / round-robin encoder with valid/ready on both sides,
// zero and multi-hot flags, and a saturating count of non-one-hot inputs.
module prio_encoder_rr
  import prio_encoder_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int MODE  = MODE_FIXED,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic             out_none,
  output logic             out_multi,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic [W-1:0]     LAST_IDX = W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [W-1:0] rr_ptr;
  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic         accept;
  vec_class_e   cls;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cls      = classify(64'(in_req));

  prio_pick #(
    .N    (N),
    .W    (W),
    .MODE (MODE)
  ) u_pick (
    .req   (in_req),
    .start (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_none  <= 1'b0;
      out_multi <= 1'b0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_idx   <= pick_found ? pick_idx : '0;
      out_none  <= (cls == CLS_ZERO);
      out_multi <= (cls == CLS_MULTI);
      // The pointer only moves on a real grant; a zero vector leaves it parked.
      if (MODE == MODE_RR && pick_found)
        rr_ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (accept && cls != CLS_ONE && err_cnt != CNT_MAX)
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench driving three encoder variants (fixed N=8, round-robin N=8 with a 2-bit
// counter, round-robin N=5) from shared stimulus against a behavioural reference model.
module tb_prio_encoder_rr;

  typedef struct {
    int idx;
    bit none;
    bit multi;
  } exp_t;

  localparam int NS    [3] = '{8, 8, 5};
  localparam int MODES [3] = '{0, 1, 1};
  localparam int MAXC  [3] = '{255, 3, 7};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_req = 8'h00;
  logic       out_ready = 1'b1;
  logic       err_clr = 1'b0;

  logic       ir0, ir1, ir2;
  logic       ov0, ov1, ov2;
  logic [2:0] idx0, idx1, idx2;
  logic       on0, on1, on2;
  logic       om0, om1, om2;
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic [2:0] ec2;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8), .MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_req(in_req),
    .out_valid(ov0), .out_ready(out_ready), .out_idx(idx0), .out_none(on0),
    .out_multi(om0), .err_cnt(ec0), .err_clr(err_clr));

  prio_encoder_rr #(.N(8), .MODE(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_req(in_req),
    .out_valid(ov1), .out_ready(out_ready), .out_idx(idx1), .out_none(on1),
    .out_multi(om1), .err_cnt(ec1), .err_clr(err_clr));

  prio_encoder_rr #(.N(5), .MODE(1), .CNT_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_req(in_req[4:0]),
    .out_valid(ov2), .out_ready(out_ready), .out_idx(idx2), .out_none(on2),
    .out_multi(om2), .err_cnt(ec2), .err_clr(err_clr));

  exp_t expq [3][$];
  bit   mv      [3] = '{0, 0, 0};
  int   ptr_m   [3] = '{0, 0, 0};
  int   err_m   [3] = '{0, 0, 0};
  bit   chk_rst [3] = '{0, 0, 0};
  bit   armed = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] @%0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  // Reference: count set bits, then scan upward from the start point with modulo wrap.
  function automatic exp_t ref_pick(input logic [7:0] req, input int n, input int mode,
                                    input int ptr);
    exp_t e;
    int   cnt;
    bit   got;
    int   b;
    cnt = 0;
    for (int i = 0; i < n; i++) cnt += int'(req[i]);
    e.none  = (cnt == 0);
    e.multi = (cnt > 1);
    e.idx   = 0;
    got     = 0;
    for (int s = 0; s < n; s++) begin
      b = (mode == 1) ? (ptr + s) % n : s;
      if (!got && req[b]) begin
        e.idx = b;
        got   = 1;
      end
    end
    return e;
  endfunction

  // Predictor: at each edge decide what the DUT accepts and push the expected result.
  always @(posedge clk) begin
    exp_t e;
    bit   acc;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        expq[k].delete();
        mv[k]      = 0;
        ptr_m[k]   = 0;
        err_m[k]   = 0;
        chk_rst[k] = 1;
        armed      = 1;
      end else begin
        acc = in_valid && (!mv[k] || out_ready);
        e.none  = 0;
        e.multi = 0;
        e.idx   = 0;
        if (acc) begin
          e = ref_pick(in_req, NS[k], MODES[k], ptr_m[k]);
          expq[k].push_back(e);
          mv[k] = 1;
          if (MODES[k] == 1 && !e.none) ptr_m[k] = (e.idx + 1) % NS[k];
        end else if (mv[k] && out_ready) begin
          mv[k] = 0;
        end
        if (err_clr)
          err_m[k] = 0;
        else if (acc && (e.none || e.multi) && err_m[k] < MAXC[k])
          err_m[k]++;
      end
    end
  end

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    logic ov, ir, on, om;
    int   idx, ec;
    exp_t e;
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       begin ov = ov0; ir = ir0; on = on0; om = om0; idx = int'(idx0); ec = int'(ec0); end
          1:       begin ov = ov1; ir = ir1; on = on1; om = om1; idx = int'(idx1); ec = int'(ec1); end
          default: begin ov = ov2; ir = ir2; on = on2; om = om2; idx = int'(idx2); ec = int'(ec2); end
        endcase
        chk("out_valid", k, longint'(ov), longint'(mv[k]));
        chk("in_ready", k, longint'(ir), longint'(!mv[k] || out_ready));
        chk("err_cnt", k, longint'(ec), longint'(err_m[k]));
        if (chk_rst[k]) begin
          chk("rst_idx", k, longint'(idx), 0);
          chk("rst_flags", k, longint'({on, om}), 0);
          chk_rst[k] = 0;
        end
        if (ov && expq[k].size() > 0) begin
          e = expq[k][0];
          chk("out_idx", k, longint'(idx), longint'(e.idx));
          chk("out_none", k, longint'(on), longint'(e.none));
          chk("out_multi", k, longint'(om), longint'(e.multi));
          if (out_ready) void'(expq[k].pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] r, input logic ordy, input logic clr);
    in_valid  = v;
    in_req    = r;
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] r;
    int         t;
    rst_n = 1'b0;
    drive(0, 8'h00, 1, 0);
    drive(0, 8'h00, 1, 0);
    rst_n = 1'b1;
    drive(0, 8'h00, 1, 0);

    // One-hot sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      r = 8'h01 << i;
      drive(1, r, 1, 0);
    end
    // Zero then multi-hot
    drive(1, 8'h00, 1, 0);
    drive(1, 8'h28, 1, 0);
    // All-ones held for ten accepts: round-robin walks and wraps
    for (int i = 0; i < 10; i++) drive(1, 8'hFF, 1, 0);
    drive(0, 8'h00, 1, 0);

    // Backpressure: stall three cycles with a pending input, then transfer + accept together
    drive(1, 8'h04, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 8'h10, 0, 0);
    drive(1, 8'h10, 1, 0);
    drive(0, 8'h00, 1, 0);

    // Counter saturation and clear priority
    drive(1, 8'h03, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 8'h0C, 1, 0);
    drive(1, 8'h30, 1, 1);
    drive(0, 8'h00, 1, 0);

    // Reset while a result is held and the pointer is parked mid-vector
    drive(1, 8'h10, 1, 0);
    drive(1, 8'h02, 0, 0);
    rst_n = 1'b0;
    drive(1, 8'h02, 0, 0);
    rst_n = 1'b1;
    drive(1, 8'hFF, 1, 0);
    drive(0, 8'h00, 1, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      t = int'($urandom_range(0, 9));
      if (t < 4)       r = 8'h01 << $urandom_range(0, 7);
      else if (t == 4) r = 8'h00;
      else             r = 8'($urandom());
      rst_n = ($urandom_range(0, 299) != 0);
      drive(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 49) == 0));
    end
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) drive(0, 8'h00, 1, 0);
    for (int k = 0; k < 3; k++) chk("drain", k, longint'(expq[k].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
